instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter N, default 2, program address width in bits; 2^N ROM words.
REQ-002 Parameter HALT_OPCODE, default 8'hFF, instruction word that stops fetching.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  level; leaves IDLE and begins fetching.
REQ-006 stall  input  1  level; holds all fetch state while in RUN.
REQ-007 jump_en  input  1  load jump_addr into PC this cycle.
REQ-008 jump_addr  input  N  jump target address.
REQ-009 resume  input  1  leaves HALT and continues fetching.
REQ-010 rom_data  input  8  combinational ROM word at rom_addr, valid in the same cycle.
REQ-011 rom_addr  output  N  ROM address, equal to pc at all times.
REQ-012 pc  output  N  current program counter.
REQ-013 instr  output  8  registered fetched instruction.
REQ-014 instr_valid  output  1  instr holds a new instruction this cycle (1-cycle pulse per fetch).
REQ-015 halted  output  1  high while in HALT.
REQ-016 wrap  output  1  1-cycle pulse when PC incremented from 2^N-1 to 0.

Function
REQ-017 FSM states IDLE, RUN, HALT; encoding free; exactly one active.
REQ-018 IDLE: pc, instr held; instr_valid=0; start=1 -> RUN at next edge, no fetch on that edge.
REQ-019 RUN, jump_en=1: pc <= jump_addr, instr held, instr_valid <= 0; jump_en wins over stall and halt detection.
REQ-020 RUN, jump_en=0, stall=1: pc, instr held; instr_valid <= 0; wrap <= 0.
REQ-021 RUN, jump_en=0, stall=0: instr <= rom_data, instr_valid <= 1, pc <= pc+1 modulo 2^N.
REQ-022 Fetch latency: word at address A appears on instr with instr_valid=1 one edge after the RUN cycle in which pc=A and fetch conditions of REQ-021 hold.
REQ-023 PC increment from 2^N-1 wraps to 0; wrap <= 1 on that edge only, else wrap <= 0.
REQ-024 Fetch of rom_data == HALT_OPCODE under REQ-021: instr <= HALT_OPCODE, instr_valid <= 1, pc increments, state -> HALT.
REQ-025 HALT: pc, instr held; instr_valid=0; halted=1; stall and jump_en ignored.
REQ-026 HALT, resume=1: -> RUN at next edge, halted <= 0, no fetch on that edge; fetching continues from held pc.
REQ-027 start ignored outside IDLE; resume ignored outside HALT.
REQ-028 halted is a registered output; high in the cycle after the HALT-entry edge.
REQ-029 No combinational path from any input to any output except rom_addr = pc.

Reset
REQ-030 rst=1 asserts immediately, independent of clk: state=IDLE, pc=0, instr=8'h00, instr_valid=0, halted=0, wrap=0.
REQ-031 rst mid-fetch, mid-stall or in HALT discards all in-flight state; after release, block waits in IDLE for start.
REQ-032 First edge after rst release with start=1 only enters RUN.

Verification
REQ-033 N=2, ROM {10,30,40,80}, start pulse, no stall -> instr 10,30,40,80,10 on successive edges, instr_valid=1 each; wrap=1 with the edge that presents 80 (pc 3->0).
REQ-034 stall=1 for 3 cycles after instr=30 -> instr stays 30, instr_valid=0, pc=2 held; on release next instr=40.
REQ-035 jump_en=1, jump_addr=3, together with stall=1 while pc=1 -> pc=3, instr_valid=0 next cycle; following edge instr=80.
REQ-036 ROM {10,FF,40,80} -> instr=FF with instr_valid=1, then halted=1, pc=2 frozen for 5 cycles despite jump_en; resume -> next fetched instr=40.
REQ-037 Assert rst asynchronously between edges while in RUN with pc=2 -> outputs reset immediately (pc=0, instr=00, instr_valid=0), stays IDLE until start.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/RUN/HALT sequencer driving a PC into a combinational ROM
// and registering the fetched word, with stall, jump, halt-on-opcode and wrap flag.
module instruction_fetch #(
  parameter int         N           = 2,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         stall_i,
  input  logic         jump_en_i,
  input  logic [N-1:0] jump_addr_i,
  input  logic         resume_i,
  input  logic [7:0]   rom_data_i,
  output logic [N-1:0] rom_addr_o,
  output logic [N-1:0] pc_o,
  output logic [7:0]   instr_o,
  output logic         instr_valid_o,
  output logic         halted_o,
  output logic         wrap_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [N-1:0] PC_MAX = {N{1'b1}};

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [7:0]   instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         halted_q, halted_d;
  logic         wrap_q, wrap_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= 8'h00;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      wrap_q        <= wrap_d;
    end
  end

  // Pulses (instr_valid, wrap) default low; only a RUN fetch raises them.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    halted_d      = 1'b0;
    wrap_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (jump_en_i) begin
          pc_d = jump_addr_i;
        end else if (!stall_i) begin
          instr_d       = rom_data_i;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 1'b1;
          wrap_d        = (pc_q == PC_MAX);
          if (rom_data_i == HALT_OPCODE) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
        end
      end
      HALT: begin
        halted_d = 1'b1;
        if (resume_i) begin
          state_d  = RUN;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rom_addr_o    = pc_q;
  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign halted_o      = halted_q;
  assign wrap_o        = wrap_q;

endmodule
